// File: rtl/hs_pkg.sv
// Shared handshake helpers for the pack/unpack/width-converter stages:
// a constant log2 and a slot-count-to-thermometer keep mask.
package hs_pkg;

    localparam int unsigned KEEP_MAX_W = 64;

    // Never returns 0 so that a counter built from it always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'(1) << res) < 64'(value)) begin
            res = res + 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

    // Slot index -> mask with bits [idx:0] set.
    function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int unsigned idx);
        return (KEEP_MAX_W'(1) << (idx + 1)) - KEEP_MAX_W'(1);
    endfunction

endpackage

// File: rtl/hs_pack.sv
// Valid/ready width packer: gathers RATIO beats of DATA_WD bits into one word,
// with last_in closing a partial word early (unused slots zeroed, flagged in keep_out).
module hs_pack
    import hs_pkg::*;
#(
    parameter int unsigned DATA_WD = 4,
    parameter int unsigned RATIO   = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       valid_in,
    input  logic [DATA_WD-1:0]         data_in,
    input  logic                       last_in,
    output logic                       ready_in,
    output logic                       valid_out,
    output logic [DATA_WD*RATIO-1:0]   data_out,
    output logic [RATIO-1:0]           keep_out,
    input  logic                       ready_out
);

    localparam int unsigned CNT_W  = clog2(RATIO);
    localparam int unsigned WORD_W = DATA_WD * RATIO;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    if (RATIO < 2 || RATIO > KEEP_MAX_W) begin : g_bad_ratio
        $fatal(1, "hs_pack: RATIO must be in 2..%0d", KEEP_MAX_W);
    end
    if (DATA_WD < 1) begin : g_bad_data_wd
        $fatal(1, "hs_pack: DATA_WD must be at least 1");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [RATIO-1:0]  acc_keep_q, acc_keep_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [RATIO-1:0]  keep_q, keep_d;

    logic              fire_in;
    logic              fire_out;
    logic              word_done;
    logic [WORD_W-1:0] merged;
    logic [RATIO-1:0]  keep_new;

    // ready_in depends only on the output register and ready_out, never on valid_in.
    assign ready_in  = !valid_q || ready_out;
    assign fire_in   = valid_in && ready_in;
    assign fire_out  = valid_q && ready_out;
    assign word_done = fire_in && (last_in || (cnt_q == CNT_LAST));

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;

    // Only slots flagged in acc_keep are carried, so everything above cnt is zero.
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (acc_keep_q[i]) begin
                merged[i*DATA_WD +: DATA_WD] = acc_q[i*DATA_WD +: DATA_WD];
            end
        end
        merged[int'(cnt_q)*DATA_WD +: DATA_WD] = data_in;
        keep_new = RATIO'(keep_mask(int'(cnt_q)));
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        if (fire_in) begin
            if (word_done) begin
                cnt_d      = '0;
                acc_d      = '0;
                acc_keep_d = '0;
            end else begin
                acc_d[int'(cnt_q)*DATA_WD +: DATA_WD] = data_in;
                acc_keep_d[cnt_q] = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A completing beat overrides the drain, so back-to-back words have no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (fire_out) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            valid_d = 1'b1;
            data_d  = merged;
            keep_d  = keep_new;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

endmodule

// File: doc/hs_pack.md
# hs_pack

Valid/ready width packer that sits directly downstream of the handshake buffer stage. It gathers `RATIO` consecutive `DATA_WD`-bit beats into one `DATA_WD*RATIO`-bit word and presents that word on a registered valid/ready output. A `last_in` marker closes a partial word early; the unfilled slots are zeroed and flagged in `keep_out`. The block sustains full throughput: one beat per cycle in while the downstream is ready.

## Interface
- `DATA_WD`, default 4, width of one input beat; must be ≥1.
- `RATIO`, default 4, beats per output word; must be ≥2 (1 is unsupported).
- `clk` input 1: clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `valid_in` input 1: upstream beat valid.
- `data_in` input `DATA_WD`: upstream beat payload.
- `last_in` input 1: beat closes the current word; qualified by `valid_in`.
- `ready_in` output 1: block accepts the beat this cycle.
- `valid_out` output 1: packed word valid, registered.
- `data_out` output `DATA_WD*RATIO`: packed word, registered.
- `keep_out` output `RATIO`: per-slot valid mask, registered.
- `ready_out` input 1: downstream accepts the word.

## Operation
- Fire events:
  - `fire_in = valid_in & ready_in`.
  - `fire_out = valid_out & ready_out`.
- `ready_in = !valid_out | ready_out`. This is combinational from `ready_out` only, never from `valid_in`, `data_in` or `last_in`.
- Internal state:
  - Slot counter `cnt`, width `$clog2(RATIO)`, values 0..`RATIO`-1.
  - Accumulator `acc` of `DATA_WD*RATIO` bits.
  - Accumulator mask `acc_keep` of `RATIO` bits.
- Slot ordering: the first beat of a word lands in slot 0 (bits `[DATA_WD-1:0]`). Slot `i` occupies bits `[i*DATA_WD +: DATA_WD]`.
- Behaviour on `fire_in`:
  - When the beat completes a word (`cnt == RATIO-1` or `last_in == 1`):
    - `data_out` ← `acc` merged with the beat in slot `cnt`; slots above `cnt` are forced to zero.
    - `keep_out` ← `(1 << (cnt+1)) - 1`.
    - `valid_out` ← 1.
    - `cnt` ← 0, `acc` ← 0, `acc_keep` ← 0.
  - Otherwise: the beat is written into `acc` slot `cnt`, `acc_keep[cnt]` ← 1, and `cnt` ← `cnt` + 1.
- `valid_out` is cleared on `fire_out` unless a new word completes in the same cycle.
- Output stability: while `valid_out & !ready_out`, `data_out` and `keep_out` hold and `ready_in` = 0.
- `last_in` at `cnt == RATIO-1` is identical to normal completion (`keep_out` all ones).
- `last_in` on a beat with `cnt == 0` produces a one-slot word, `keep_out = 1`.
- Wrap-around: `cnt` returns to 0 after every completion; there is no overflow state.
- Reset values (asserted asynchronously, released synchronously by the clock):
  - `valid_out` = 0, `data_out` = 0, `keep_out` = 0.
  - `cnt` = 0, `acc` = 0, `acc_keep` = 0.
- Reset in the middle of a word discards both the partial accumulator and any pending output word. The next beat after reset lands in slot 0.

## Timing
- Latency: a word whose completing beat fires at edge `k` shows `valid_out` = 1 in the cycle after edge `k`.
- Throughput: with `ready_out` held at 1, `ready_in` stays 1 permanently, giving 1 beat/cycle in and 1 word per `RATIO` cycles out.
- Simultaneous `fire_out` and completing `fire_in`: `valid_out` stays 1 and the new word replaces the old one at the same edge. There is no bubble.
- Simultaneous `fire_out` and a non-completing `fire_in`: `valid_out` drops to 0 and the beat enters `acc`.
- Backpressure: `ready_out` = 0 with `valid_out` = 1 stalls the input in the same cycle.
- `ready_out` may toggle freely.
- No combinational path exists from `valid_in` to `ready_in`, nor from `valid_in` to any output.

## Structure
- Shared handshake package `hs_pkg` carries:
  - a `clog2` constant function;
  - the `keep` mask helper function (`cnt` → thermometer mask).
- These helpers are reused by later unpack and width-converter stages.
- No sub-module: the block is a single flat module with one accumulator process and one output-register process.
- Parameter checks (`RATIO` ≥ 2, `DATA_WD` ≥ 1) are done at elaboration; an illegal value is a fatal error.

## Test plan
Parameters `DATA_WD`=4, `RATIO`=4; the bench uses the random-valid / random-ready driving style as a background test alongside these directed cases.
- **Basic word:** beats 1, 2, 3, 4 with `ready_out` = 1 → `data_out` = 16'h4321, `keep_out` = 4'hF, and `valid_out` is high for exactly one cycle, one cycle after the fourth fire.
- **Continuous stream:** beats 0..7 back-to-back with `ready_out` = 1 → words 16'h3210 then 16'h7654 four cycles apart, and `ready_in` never drops.
- **Early close:** beats A, B with `last_in` on B → `data_out` = 16'h00BA, `keep_out` = 4'h3. The following beats C, D, E, F give 16'hFEDC, `keep_out` = 4'hF.
- **Last on first beat / last on final slot:**
  - `last_in` on a single beat 5 → 16'h0005, `keep_out` = 4'h1.
  - `last_in` on the fourth beat → `keep_out` = 4'hF, with no extra word emitted.
- **Backpressure:** word 16'h4321 pending with `ready_out` = 0 for 10 cycles → `ready_in` = 0 and `data_out` stable throughout. On `ready_out` = 1, the word fires and the next word 16'h8765 arrives with no lost or duplicated beats.
- **Reset mid-word:** beats 1, 2, then `rstn` low for 2 cycles → all outputs 0. After release, beats 9, A, B, C give 16'hCBA9 with no residue from the beats before reset.
